// File: rtl/mc6502_bus_if.sv
// mc6502_bus_if
//   Memory bus interface for the MC6502 core. It captures the datapath
//   address and write data plus the read/write strobe when the core
//   requests an access, runs a valid/ready transaction on the memory port,
//   and holds the core with stall_o until that transaction completes.
//   A memory that never answers is aborted after P_TIMEOUT request cycles.
//   The abort raises a sticky bus_err_o, and on a read it loads P_ERR_DATA
//   into db_in_o.
//
// Ports
//   clk_i          system clock, rising edge
//   res_i          asynchronous active-high reset
//   bus_req_i      access request, sampled only in IDLE
//   rw_i           1 = read, 0 = write, sampled with bus_req_i
//   abl_i/abh_i    address low/high byte from the datapath
//   db_out_i       write data from the datapath
//   db_in_o        registered read data to the datapath
//   stall_o        core must hold state while high
//   bus_err_o      sticky timeout flag
//   err_clr_i      synchronous clear of bus_err_o (a timeout on the same edge wins)
//   mem_valid_o    transaction request to memory
//   mem_addr_o     captured {abh, abl}
//   mem_wdata_o    captured write data
//   mem_we_o       write strobe
//   mem_re_o       read strobe
//   mem_ready_i    memory completes the transaction this cycle
//   mem_rdata_i    read data, valid with mem_ready_i on a read
module mc6502_bus_if #(
  parameter logic [7:0] P_TIMEOUT  = 8'd16,
  parameter logic [7:0] P_DB_INIT  = 8'h00,
  parameter logic [7:0] P_ERR_DATA = 8'hff
) (
  input  logic        clk_i,
  input  logic        res_i,
  input  logic        bus_req_i,
  input  logic        rw_i,
  input  logic [7:0]  abl_i,
  input  logic [7:0]  abh_i,
  input  logic [7:0]  db_out_i,
  output logic [7:0]  db_in_o,
  output logic        stall_o,
  output logic        bus_err_o,
  input  logic        err_clr_i,
  output logic        mem_valid_o,
  output logic [15:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic        mem_ready_i,
  input  logic [7:0]  mem_rdata_i
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  db_in_q, db_in_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic        timeout;

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 8'd0;
      db_in_q    <= P_DB_INIT;
      bus_err_q  <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      db_in_q    <= db_in_d;
      bus_err_q  <= bus_err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    db_in_d    = db_in_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    timeout    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus_req_i) begin
          addr_d     = {abh_i, abl_i};
          wdata_d    = db_out_i;
          rw_d       = rw_i;
          wait_cnt_d = 8'd0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        // A ready on the last allowed cycle takes priority over the abort.
        if (mem_ready_i) begin
          if (rw_q) db_in_d = mem_rdata_i;
          state_d = ST_IDLE;
        end else if (wait_cnt_q == P_TIMEOUT - 8'd1) begin
          timeout = 1'b1;
          if (rw_q) db_in_d = P_ERR_DATA;
          state_d = ST_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Setting the error flag takes priority over clearing it.
    if (timeout)        bus_err_d = 1'b1;
    else if (err_clr_i) bus_err_d = 1'b0;
    else                bus_err_d = bus_err_q;
  end

  // Outputs come from registers or are decoded from state, so reset drops
  // mem_valid_o and stall_o immediately.
  assign mem_valid_o = (state_q == ST_REQ);
  assign stall_o     = (state_q == ST_REQ);
  assign mem_we_o    = (state_q == ST_REQ) & ~rw_q;
  assign mem_re_o    = (state_q == ST_REQ) & rw_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign db_in_o     = db_in_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mc6502_bus_if.sv
module tb_mc6502_bus_if;

  logic        clk = 1'b0;
  logic        res;
  logic        bus_req, rw, err_clr, mem_ready;
  logic [7:0]  abl, abh, db_out, mem_rdata;
  logic [7:0]  db_in, mem_wdata;
  logic        stall, bus_err, mem_valid, mem_we, mem_re;
  logic [15:0] mem_addr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mc6502_bus_if dut (
    .clk_i(clk), .res_i(res), .bus_req_i(bus_req), .rw_i(rw),
    .abl_i(abl), .abh_i(abh), .db_out_i(db_out), .db_in_o(db_in),
    .stall_o(stall), .bus_err_o(bus_err), .err_clr_i(err_clr),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_ready_i(mem_ready),
    .mem_rdata_i(mem_rdata)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1; bus_req = 1'b0; rw = 1'b1; err_clr = 1'b0; mem_ready = 1'b0;
    abl = 8'h00; abh = 8'h00; db_out = 8'h00; mem_rdata = 8'h00;
    tick(); tick();
    res = 1'b0;
    tick();
    tests++; if ({mem_valid, stall, mem_we, mem_re, bus_err} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_valid, stall, mem_we, mem_re, bus_err}); end
    tests++; if (db_in !== 8'h00) begin fails++; $display("FAIL reset_db_in: got %h expected 00", db_in); end
    tests++; if (mem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
    tests++; if (mem_wdata !== 8'h00) begin fails++; $display("FAIL reset_wdata: got %h expected 00", mem_wdata); end
  endtask

  task automatic test_read_zero_wait();
    abh = 8'h12; abl = 8'h34; rw = 1'b1; mem_ready = 1'b1; mem_rdata = 8'hA5; bus_req = 1'b1;
    tick();
    bus_req = 1'b0;
    tests++; if ({mem_valid, mem_re, mem_we, stall} !== 4'b1101) begin
      fails++; $display("FAIL rd0_strobes: got %b expected 1101", {mem_valid, mem_re, mem_we, stall}); end
    tests++; if (mem_addr !== 16'h1234) begin fails++; $display("FAIL rd0_addr: got %h expected 1234", mem_addr); end
    tick();
    tests++; if ({mem_re, stall} !== 2'b00) begin fails++; $display("FAIL rd0_done: got %b expected 00", {mem_re, stall}); end
    tests++; if (db_in !== 8'hA5) begin fails++; $display("FAIL rd0_db_in: got %h expected a5", db_in); end
    tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL rd0_err: got %b expected 0", bus_err); end
  endtask

  task automatic test_write_wait();
    int n;
    abh = 8'h01; abl = 8'hFF; db_out = 8'h3C; rw = 1'b0; mem_ready = 1'b0; bus_req = 1'b1;
    tick();
    bus_req = 1'b0; db_out = 8'h00;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      if (mem_we === 1'b1 && stall === 1'b1 && mem_wdata === 8'h3C && mem_addr === 16'h01FF) n++;
      tick();
    end
    mem_ready = 1'b0;
    tests++; if (n != 4) begin fails++; $display("FAIL wr_active_cycles: got %0d expected 4", n); end
    tests++; if ({mem_we, stall} !== 2'b00) begin fails++; $display("FAIL wr_done: got %b expected 00", {mem_we, stall}); end
    tests++; if (db_in !== 8'hA5) begin fails++; $display("FAIL wr_db_in: got %h expected a5", db_in); end
  endtask

  task automatic test_timeout();
    int n;
    abh = 8'h40; abl = 8'h00; rw = 1'b1; mem_ready = 1'b0; bus_req = 1'b1;
    tick();
    bus_req = 1'b0;
    n = 0;
    while (mem_valid === 1'b1 && n < 100) begin
      if (bus_err !== 1'b0) n = 1000;
      n++;
      tick();
    end
    tests++; if (n != 16) begin fails++; $display("FAIL to_valid_cycles: got %0d expected 16", n); end
    tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b expected 1", bus_err); end
    tests++; if (db_in !== 8'hFF) begin fails++; $display("FAIL to_db_in: got %h expected ff", db_in); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL to_err_clr: got %b expected 0", bus_err); end
  endtask

  task automatic test_late_ready();
    abh = 8'h50; abl = 8'h05; rw = 1'b1; mem_ready = 1'b0; mem_rdata = 8'h42; bus_req = 1'b1;
    tick();
    bus_req = 1'b0;
    repeat (15) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL late_valid: got %b expected 0", mem_valid); end
    tests++; if (db_in !== 8'h42) begin fails++; $display("FAIL late_db_in: got %h expected 42", db_in); end
    tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL late_err: got %b expected 0", bus_err); end
  endtask

  task automatic test_err_set_wins();
    rw = 1'b1; mem_ready = 1'b0; bus_req = 1'b1;
    tick();
    bus_req = 1'b0;
    repeat (15) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++; if (bus_err !== 1'b1) begin fails++; $display("FAIL setwins_err: got %b expected 1", bus_err); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL setwins_stall: got %b expected 0", stall); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL setwins_clr: got %b expected 0", bus_err); end
  endtask

  task automatic test_ignore_inputs();
    abh = 8'h56; abl = 8'h78; db_out = 8'h11; rw = 1'b0; mem_ready = 1'b0; bus_req = 1'b1;
    tick();
    bus_req = 1'b0;
    abh = 8'h9A; abl = 8'hBC; db_out = 8'hEE; rw = 1'b1; bus_req = 1'b1;
    tick(); tick();
    tests++; if (mem_addr !== 16'h5678) begin fails++; $display("FAIL ign_addr: got %h expected 5678", mem_addr); end
    tests++; if (mem_wdata !== 8'h11) begin fails++; $display("FAIL ign_wdata: got %h expected 11", mem_wdata); end
    tests++; if ({mem_we, mem_re} !== 2'b10) begin fails++; $display("FAIL ign_strobes: got %b expected 10", {mem_we, mem_re}); end
    bus_req = 1'b0; mem_ready = 1'b1;
    tick();
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL ign_done: got %b expected 0", mem_valid); end
    tick();
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL ign_no_second: got %b expected 0", mem_valid); end
    mem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    abh = 8'hAA; abl = 8'hAA; rw = 1'b1; mem_ready = 1'b1; mem_rdata = 8'h77; bus_req = 1'b1;
    tick();
    tests++; if (mem_addr !== 16'hAAAA || mem_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_first: got %h/%b expected aaaa/1", mem_addr, mem_valid); end
    tick();
    tests++; if (mem_valid !== 1'b0 || db_in !== 8'h77) begin
      fails++; $display("FAIL b2b_gap: got %b/%h expected 0/77", mem_valid, db_in); end
    abh = 8'hBB; abl = 8'hBB; mem_rdata = 8'h88;
    tick();
    tests++; if (mem_addr !== 16'hBBBB || mem_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_second: got %h/%b expected bbbb/1", mem_addr, mem_valid); end
    bus_req = 1'b0;
    tick();
    tests++; if (mem_valid !== 1'b0 || db_in !== 8'h88) begin
      fails++; $display("FAIL b2b_end: got %b/%h expected 0/88", mem_valid, db_in); end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    abh = 8'h0C; abl = 8'h0D; rw = 1'b1; mem_ready = 1'b0; bus_req = 1'b1;
    tick();
    bus_req = 1'b0;
    tick();
    #2;
    res = 1'b1;
    #1;
    tests++; if ({mem_valid, stall} !== 2'b00) begin
      fails++; $display("FAIL rstmid_ctrl: got %b expected 00", {mem_valid, stall}); end
    tests++; if (db_in !== 8'h00) begin fails++; $display("FAIL rstmid_db_in: got %h expected 00", db_in); end
    #1;
    res = 1'b0;
    tick();
    tests++; if (mem_valid !== 1'b0) begin fails++; $display("FAIL rstmid_idle: got %b expected 0", mem_valid); end
    abh = 8'h22; abl = 8'h22; rw = 1'b1; mem_ready = 1'b1; mem_rdata = 8'h5A; bus_req = 1'b1;
    tick();
    bus_req = 1'b0;
    tests++; if (mem_re !== 1'b1 || mem_addr !== 16'h2222) begin
      fails++; $display("FAIL rstmid_req: got %b/%h expected 1/2222", mem_re, mem_addr); end
    tick();
    tests++; if (db_in !== 8'h5A || stall !== 1'b0 || bus_err !== 1'b0) begin
      fails++; $display("FAIL rstmid_after: got %h/%b/%b expected 5a/0/0", db_in, stall, bus_err); end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_timeout();
    test_late_ready();
    test_err_set_wins();
    test_ignore_inputs();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
